// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave keypad and timer blocks.
package microwave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    CAPTURE,
    RELEASE,
    LOCKED
  } entry_state_t;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 3;
  localparam int BCD_MAX    = 9;

endpackage

// File: rtl/key_debouncer.sv
// Consecutive stable-sample counter, shared by the press and release phases.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  input  logic restart,
  output logic stable
);

  localparam logic [3:0] TARGET = 4'(DEBOUNCE_CYCLES);

  logic [3:0] cnt;
  logic [3:0] cnt_next;

  // stable flags the sample that completes the run, so callers can
  // leave their phase on the same edge that counts it
  always_comb begin
    cnt_next = cnt;
    if (!sample)
      cnt_next = '0;
    else if (restart)
      cnt_next = 4'd1;
    else if (cnt != 4'hF)
      cnt_next = cnt + 4'd1;
  end

  assign stable = (cnt_next >= TARGET);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else
      cnt <= cnt_next;
  end

endmodule

// File: rtl/time_entry_ctrl.sv
// Keypad time-entry controller: debounces encoder keys into a BCD cook time.
module time_entry_ctrl
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clearn,
  input  logic               lock,
  input  logic [DIGIT_W-1:0] enc_D,
  input  logic               enc_loadn,
  output logic               enc_enablen,
  output logic [DIGIT_W-1:0] minutes,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [1:0]         digits,
  output logic               key_stb
);

  entry_state_t state;
  entry_state_t state_next;

  logic [DIGIT_W-1:0] cand;
  logic db_sample;
  logic db_restart;
  logic db_stable;
  logic latch;
  logic accept;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db (
    .clk    (clk),
    .rst_n  (resetn),
    .sample (db_sample),
    .restart(db_restart),
    .stable (db_stable)
  );

  // Counter control kept apart from next-state logic to avoid a false loop
  always_comb begin
    db_sample  = 1'b0;
    db_restart = 1'b0;
    latch      = 1'b0;
    unique case (state)
      IDLE: begin
        db_restart = 1'b1;
        db_sample  = !enc_loadn;
        latch      = !enc_loadn;
      end
      DEBOUNCE: begin
        db_sample = !enc_loadn;
        if (!enc_loadn && enc_D != cand) begin
          db_restart = 1'b1;
          latch      = 1'b1;
        end
      end
      CAPTURE: db_restart = 1'b1;
      RELEASE: db_sample  = enc_loadn;
      LOCKED:  db_restart = 1'b1;
      default: db_restart = 1'b1;
    endcase
    if (lock) begin
      db_sample  = 1'b0;
      db_restart = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:
        if (!enc_loadn)
          state_next = db_stable ? CAPTURE : DEBOUNCE;
      DEBOUNCE:
        if (enc_loadn)
          state_next = IDLE;
        else if (db_stable)
          state_next = CAPTURE;
      CAPTURE:
        state_next = RELEASE;
      RELEASE:
        if (db_stable)
          state_next = IDLE;
      LOCKED:
        if (!lock)
          state_next = RELEASE;
      default:
        state_next = IDLE;
    endcase
    if (lock)
      state_next = LOCKED;
  end

  assign accept = (state == CAPTURE) && !lock
               && (cand <= DIGIT_W'(BCD_MAX))
               && (digits < 2'(NUM_DIGITS));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cand        <= '0;
      enc_enablen <= 1'b0;
      minutes     <= '0;
      sec_tens    <= '0;
      sec_ones    <= '0;
      digits      <= '0;
      key_stb     <= 1'b0;
    end else begin
      state       <= state_next;
      enc_enablen <= (state_next == LOCKED);
      key_stb     <= 1'b0;
      if (latch)
        cand <= enc_D;
      if (!clearn) begin
        minutes  <= '0;
        sec_tens <= '0;
        sec_ones <= '0;
        digits   <= '0;
      end else if (accept) begin
        minutes  <= sec_tens;
        sec_tens <= sec_ones;
        sec_ones <= cand;
        digits   <= digits + 2'd1;
        key_stb  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_time_entry_ctrl.sv
// Scoreboard bench for time_entry_ctrl: strobes checked against a queue.
module tb_time_entry_ctrl;

  localparam int N = 4;

  typedef struct {
    logic [3:0] d;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       clearn;
  logic       lock;
  logic [3:0] enc_D;
  logic       enc_loadn;
  logic       enc_enablen;
  logic [3:0] minutes;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [1:0] digits;
  logic       key_stb;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_t exp_q[$];
  exp_t mon_e;

  logic [3:0] m_min;
  logic [3:0] m_tens;
  logic [3:0] m_ones;
  int         m_cnt;

  time_entry_ctrl #(
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .clearn     (clearn),
    .lock       (lock),
    .enc_D      (enc_D),
    .enc_loadn  (enc_loadn),
    .enc_enablen(enc_enablen),
    .minutes    (minutes),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .digits     (digits),
    .key_stb    (key_stb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resetn && key_stb) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe cyc=%0d digit=%0d required no strobe",
                 cyc, sec_ones);
      end else begin
        mon_e = exp_q.pop_front();
        if (sec_ones !== mon_e.d || cyc != mon_e.cyc) begin
          failures++;
          $display("FAIL strobe got digit=%0d cyc=%0d required digit=%0d cyc=%0d",
                   sec_ones, cyc, mon_e.d, mon_e.cyc);
        end
      end
    end
  end

  task automatic model_clear();
    m_min  = 0;
    m_tens = 0;
    m_ones = 0;
    m_cnt  = 0;
  endtask

  task automatic press(input logic [3:0] d, input int hold, input int rel);
    exp_t e;
    @(negedge clk);
    enc_D     = d;
    enc_loadn = 1'b0;
    if (hold >= N && d <= 4'd9 && m_cnt < 3) begin
      e.d   = d;
      e.cyc = cyc + 1 + N;
      exp_q.push_back(e);
      m_min  = m_tens;
      m_tens = m_ones;
      m_ones = d;
      m_cnt++;
    end
    repeat (hold) @(negedge clk);
    enc_loadn = 1'b1;
    repeat (rel) @(negedge clk);
  endtask

  task automatic check_regs(input string name);
    checks++;
    if (minutes !== m_min || sec_tens !== m_tens || sec_ones !== m_ones
        || digits !== 2'(m_cnt)) begin
      failures++;
      $display("FAIL %s got %0d%0d%0d digits=%0d required %0d%0d%0d digits=%0d",
               name, minutes, sec_tens, sec_ones, digits,
               m_min, m_tens, m_ones, m_cnt);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s missing_strobes got %0d pending required 0",
               name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clearn = 1'b0;
    @(negedge clk);
    clearn = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    clearn    = 1'b1;
    lock      = 1'b0;
    enc_D     = 4'd0;
    enc_loadn = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    checks++;
    if ({enc_enablen, key_stb} !== 2'b00) begin
      failures++;
      $display("FAIL reset_ctrl got enablen=%b stb=%b required 0 0",
               enc_enablen, key_stb);
    end
    check_regs("reset_regs");
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_entry();
    press(4'd1, 6, 6);
    press(4'd2, 6, 6);
    press(4'd5, 6, 6);
    check_regs("entry");
    check_drained("entry");
  endtask

  task automatic test_full_invalid();
    press(4'd9, 6, 6);
    check_regs("full_press9");
    pulse_clear();
    check_regs("clear");
    press(4'hC, 6, 6);
    check_regs("invalid_C");
    check_drained("full_invalid");
  endtask

  task automatic test_bounce();
    exp_t e;
    @(negedge clk);
    enc_D     = 4'd7;
    enc_loadn = 1'b0;
    repeat (3) @(negedge clk);
    enc_loadn = 1'b1;
    @(negedge clk);
    enc_loadn = 1'b0;
    e.d   = 4'd7;
    e.cyc = cyc + 1 + N;
    exp_q.push_back(e);
    m_ones = 4'd7;
    m_cnt  = 1;
    repeat (5) @(negedge clk);
    enc_loadn = 1'b1;
    repeat (6) @(negedge clk);
    check_regs("bounce");
    check_drained("bounce");
  endtask

  task automatic test_hold_lock();
    press(4'd3, 50, 6);
    check_regs("hold");
    @(negedge clk);
    enc_D     = 4'd6;
    enc_loadn = 1'b0;
    repeat (2) @(negedge clk);
    lock = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (enc_enablen !== 1'b1) begin
      failures++;
      $display("FAIL lock_enablen got %b required 1", enc_enablen);
    end
    lock = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (enc_enablen !== 1'b0) begin
      failures++;
      $display("FAIL unlock_enablen got %b required 0", enc_enablen);
    end
    check_regs("lock_held");
    enc_loadn = 1'b1;
    repeat (6) @(negedge clk);
    press(4'd6, 6, 6);
    check_regs("after_lock");
    check_drained("hold_lock");
  endtask

  task automatic test_clear_race();
    pulse_clear();
    press(4'd2, 6, 6);
    check_regs("race_pre");
    @(negedge clk);
    enc_D     = 4'd8;
    enc_loadn = 1'b0;
    repeat (N) @(negedge clk);
    clearn = 1'b0;
    @(negedge clk);
    clearn = 1'b1;
    model_clear();
    checks++;
    if (key_stb !== 1'b0) begin
      failures++;
      $display("FAIL race_stb got %b required 0", key_stb);
    end
    check_regs("race_clear");
    enc_loadn = 1'b1;
    repeat (6) @(negedge clk);
    press(4'd4, 6, 6);
    @(negedge clk);
    enc_D     = 4'd5;
    enc_loadn = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    model_clear();
    checks++;
    if ({enc_enablen, key_stb} !== 2'b00) begin
      failures++;
      $display("FAIL async_reset_ctrl got enablen=%b stb=%b required 0 0",
               enc_enablen, key_stb);
    end
    check_regs("async_reset");
    @(negedge clk);
    enc_loadn = 1'b1;
    resetn    = 1'b1;
    repeat (2) @(negedge clk);
    press(4'd9, 6, 6);
    check_regs("post_reset");
    check_drained("clear_race");
  endtask

  initial begin
    test_reset();
    test_entry();
    test_full_invalid();
    test_bounce();
    test_hold_lock();
    test_clear_race();
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_entry_ctrl.md
# time_entry_ctrl

Keypad time-entry controller for the microwave. It gates the keyboard encoder through `enc_enablen` and debounces the encoder's `loadn`/`D` handshake. Each accepted digit is shifted into a 3-digit BCD cook-time register (minutes, seconds-tens, seconds-ones), which feeds the countdown timer. Entry is locked out while cooking.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable samples required for a press and for a release; legal range 1–15.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `clearn`  in  1  synchronous, active-low clear of the entered time (Clear button)
- `lock`  in  1  high while cooking; blocks digit entry
- `enc_D`  in  4  encoder digit code
- `enc_loadn`  in  1  encoder key-present strobe; low while a key is held
- `enc_enablen`  out  1  encoder enable, active low; 1 only in LOCKED
- `minutes`  out  4  BCD minutes digit
- `sec_tens`  out  4  BCD seconds-tens digit
- `sec_ones`  out  4  BCD seconds-ones digit
- `digits`  out  2  number of digits entered, 0–3
- `key_stb`  out  1  one-cycle pulse for each accepted digit

## Operation
FSM states: IDLE, DEBOUNCE, CAPTURE, RELEASE, LOCKED.
- **IDLE:** on `enc_loadn`=0, latch `enc_D` as the candidate, set `cnt`=1, go to DEBOUNCE.
- **DEBOUNCE:**
  - `enc_loadn`=0 and `enc_D`==candidate: increment `cnt`.
  - `enc_loadn`=1: return to IDLE.
  - `enc_D`≠candidate: re-latch the candidate and set `cnt`=1.
  - When `cnt`==`DEBOUNCE_CYCLES`, go to CAPTURE.
- **CAPTURE** (exactly 1 cycle), accept when candidate ≤9 and `digits`<3:
  - Shift: `minutes`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←candidate.
  - `digits`+=1 and pulse `key_stb`.
  - Otherwise (candidate >9, or `digits`==3): no update and no strobe.
  - Always go to RELEASE.
- **RELEASE:** requires `DEBOUNCE_CYCLES` consecutive samples of `enc_loadn`=1; any low sample restarts the count; then go to IDLE. A held key is captured once only.
- **LOCKED:** entered from any state on the edge that samples `lock`=1; `enc_enablen`=1. When `lock` falls, go to RELEASE so that a key held during cooking is never captured.

Boundary rules:
- Priority is `resetn` > `lock` > `clearn` > capture. If `lock`=1 is sampled in the same cycle a capture would occur, the capture is dropped.
- `clearn`=0 zeroes all three digits and `digits` on that edge and suppresses any coincident capture. The FSM state is not affected.
- Digits are not normalised: `sec_tens` may be 6–9. The downstream timer handles this.
- Reset value of every output is 0, including `enc_enablen`=0 (encoder enabled). FSM resets to IDLE, `cnt` and candidate to 0.

## Timing
- Let E0 be the first edge sampling `enc_loadn`=0. If the same `enc_D` is sampled at edges E0 … E0+N−1 (N=`DEBOUNCE_CYCLES`), then CAPTURE is the cycle after edge E0+N−1. The digit registers, `digits` and `key_stb` update at edge E0+N.
- Press-to-strobe latency is N edges. `key_stb` is high for exactly one cycle.
- Minimum interval between accepted keys is 2N+1 cycles: N for press debounce, 1 for CAPTURE, N for release.
- `enc_enablen` changes on the edge after `lock` is sampled; it is a registered output.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared package `microwave_pkg` holds:
  - FSM state enum `entry_state_t`
  - `DIGIT_W`=4, `NUM_DIGITS`=3, `BCD_MAX`=9
- One natural sub-module, `key_debouncer`: the stable-sample counter, parameterised by `DEBOUNCE_CYCLES`. It has inputs `sample` and `restart` and output `stable`. It is instantiated once and reused for both the press and release phases.
- Digit shift register and `digits` counter live in the top module.

## Test plan
- **Entry:** N=4, press 1, 2, 5 (each held 6 cycles, released 6 cycles) → `minutes`=1, `sec_tens`=2, `sec_ones`=5, `digits`=3, three `key_stb` pulses, each 4 edges after press.
- **Bounce:** `enc_loadn` low for 3 cycles, high for 1, low for 5 with D=7 → exactly one capture of 7, 4 edges after the second falling sample.
- **Full/invalid:** after 3 digits, press 9 → no strobe and registers unchanged. After clear, `enc_D`=4'hC held → no strobe and `digits`=0.
- **Hold and lock:** key 3 held for 50 cycles → one strobe only. Assert `lock` while key 6 is held, then deassert with the key still held → `enc_enablen`=1 during lock, no capture until release followed by a new press.
- **Clear race:** `clearn`=0 on the CAPTURE cycle → all digits 0, `digits`=0, `key_stb`=0. `resetn` low mid-DEBOUNCE → all outputs 0 immediately (asynchronous), FSM in IDLE.
